// File: rtl/bnn_acc_pkg.sv
// Shared types and helpers for the binary-convolution accumulation path.
//   term_of : popcount of a 64-bit XNOR word plus its bit-plane index,
//             converted to a signed +/-1 dot-product term (2*pop - 64) << plane.
//   sat_add : signed add with clamp to a w-bit two's-complement range,
//             returning the overflow flag next to the clamped sum.
package bnn_acc_pkg;

  localparam int POP_W       = 7;
  localparam int WORD_BITS   = 64;
  // term_of takes the plane index at this width, so PLANE_W up to 4 is supported
  localparam int PLANE_MAX_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] sum;
  } sat_t;

  function automatic logic signed [31:0] term_of(input logic [POP_W-1:0]       pop,
                                                 input logic [PLANE_MAX_W-1:0] plane);
    logic signed [31:0] d;
    d = $signed({{(32-POP_W){1'b0}}, pop});
    // matches minus mismatches over the word: pop - (64 - pop)
    d = (d <<< 1) - WORD_BITS;
    return d <<< plane;
  endfunction

  // Operands are carried at 64 bits so the raw sum is exact; w is the target width.
  function automatic sat_t sat_add(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int unsigned        w);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    sat_t               r;
    s     = a + b;
    mx    = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn    = -mx - 64'sd1;
    r.ovf = 1'b0;
    r.sum = s;
    if (s > mx) begin
      r.sum = mx;
      r.ovf = 1'b1;
    end else if (s < mn) begin
      r.sum = mn;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/popcount_term.sv
// Combinational popcount -> signed dot-product term, weighted by bit-plane.
// Ports:
//   i_pop   : popcount 0..64 of one XNOR word (values above 64 pass unchecked)
//   i_plane : bit-plane index, used as left-shift amount
//   o_term  : signed term (2*i_pop - 64) <<< i_plane
// Kept separate so a multi-lane adder tree can instantiate one per lane.
module popcount_term
  import bnn_acc_pkg::*;
#(
  parameter int PLANE_W = 2,
  parameter int TERM_W  = POP_W + 2 + (2**PLANE_W) - 1
) (
  input  logic [POP_W-1:0]          i_pop,
  input  logic [PLANE_W-1:0]        i_plane,
  output logic signed [TERM_W-1:0]  o_term
);

  assign o_term = TERM_W'(term_of(i_pop, PLANE_MAX_W'(i_plane)));

endmodule

// File: rtl/popcount_accumulator.sv
// Packet accumulator downstream of popcount64.
// Each accepted beat contributes a signed, plane-weighted term; the running sum
// saturates at ACC_W bits and one result per packet (ended by in_last) is
// presented on a single-entry valid/ready output register.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   in_pop, in_plane    : popcount and bit-plane index of the beat
//   in_last             : final beat of the packet
//   out_valid/out_ready : output handshake
//   out_sum             : saturated signed packet sum
//   out_ovf             : saturation happened somewhere in the packet
module popcount_accumulator
  import bnn_acc_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int PLANE_W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [POP_W-1:0]         in_pop,
  input  logic [PLANE_W-1:0]       in_plane,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_ovf
);

  localparam int TERM_W = POP_W + 2 + (2**PLANE_W) - 1;

  state_t                    r_state;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ovf_sticky;
  logic signed [ACC_W-1:0]   r_out_sum;
  logic                      r_out_ovf;

  logic signed [TERM_W-1:0]  w_term;
  sat_t                      w_res;
  logic signed [ACC_W-1:0]   w_sum;
  logic                      w_ovf;
  logic                      w_accept;
  logic                      w_accept_last;

  popcount_term #(
    .PLANE_W (PLANE_W),
    .TERM_W  (TERM_W)
  ) u_term (
    .i_pop   (in_pop),
    .i_plane (in_plane),
    .o_term  (w_term)
  );

  assign out_valid     = (r_state == ST_FULL);
  assign out_sum       = r_out_sum;
  assign out_ovf       = r_out_ovf;
  // Consumer readiness passes straight through so a full register can be
  // drained and refilled in the same cycle.
  assign in_ready      = !out_valid || out_ready;
  assign w_accept      = in_valid && in_ready;
  assign w_accept_last = w_accept && in_last;

  always_comb begin
    w_res = sat_add(64'(r_acc), 64'(w_term), ACC_W);
    w_sum = ACC_W'(w_res.sum);
    w_ovf = w_res.ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_EMPTY;
      r_acc        <= '0;
      r_ovf_sticky <= 1'b0;
      r_out_sum    <= '0;
      r_out_ovf    <= 1'b0;
    end else begin
      // Accumulator: a saturated value is kept and accumulation continues from it.
      if (w_accept) begin
        if (in_last) begin
          r_out_sum    <= w_sum;
          r_out_ovf    <= r_ovf_sticky | w_ovf;
          r_acc        <= '0;
          r_ovf_sticky <= 1'b0;
        end else begin
          r_acc        <= w_sum;
          r_ovf_sticky <= r_ovf_sticky | w_ovf;
        end
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_accept_last) r_state <= ST_FULL;
        end
        ST_FULL: begin
          // A new result landing in the drain cycle keeps the register full.
          if (out_ready && !w_accept_last) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/popcount_accumulator.md
Name: popcount_accumulator

Overview:
- Stage directly downstream of popcount64 in the binary/quantized convolution datapath.
- Consumes one 7-bit popcount of a 64-bit XNOR word per beat.
- Converts each popcount to a signed ±1 dot-product term (2*pop − 64), weights it by activation bit-plane (left shift), and accumulates over a packet ended by a last flag.
- Emits one saturating signed sum per packet on a valid/ready output to the threshold/quantizer stage.

Parameters:
- ACC_W, 24, width of accumulator and output sum (signed, two's complement).
- PLANE_W, 2, width of bit-plane index; shift amount 0 .. 2^PLANE_W−1.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  block accepts input beat this cycle
- in_pop  input  7  popcount 0..64 from popcount64 q
- in_plane  input  PLANE_W  bit-plane index of this beat (shift amount)
- in_last  input  1  final beat of current packet
- out_valid  output  1  out_sum/out_ovf valid
- out_ready  input  1  consumer accepts output
- out_sum  output  ACC_W  signed packet sum
- out_ovf  output  1  saturation occurred within this packet

Behaviour:
- Reset (clk edge with rst=1): acc=0, ovf_sticky=0, out_valid=0, out_sum=0, out_ovf=0. Reset wins over every other event; a partially accumulated packet is discarded.
- in_ready = !out_valid || out_ready (single output register, full throughput). Beat accepted when in_valid && in_ready.
- Term per accepted beat: t = (2*in_pop − 64) <<< in_plane, signed.
  - Range at PLANE_W=2: −512..+512.
  - in_pop > 64 is illegal; the block computes it unchecked.
- Sum: s = acc + t, computed in ACC_W+1 bits.
  - If s > 2^(ACC_W−1)−1 → clamp to max, set overflow.
  - If s < −2^(ACC_W−1) → clamp to min, set overflow.
  - Once saturated, acc keeps accumulating from the clamped value.
- Accepted beat with in_last=0: acc ← sat(s); ovf_sticky |= overflow.
- Accepted beat with in_last=1:
  - out_sum ← sat(s); out_ovf ← ovf_sticky | overflow; out_valid ← 1.
  - acc ← 0; ovf_sticky ← 0.
  - Latency: sum visible the cycle after the last beat is accepted.
- Single-beat packet (first beat has in_last=1): out_sum = t.
- Output hold: while out_valid && !out_ready, out_sum/out_ovf are stable and in_ready=0.
- Simultaneous events: out_valid && out_ready in the same cycle as an accepted in_last beat → new result loads, out_valid stays 1 (back-to-back packets, no bubble). out_ready without a new last beat → out_valid ← 0.
- States (2-state, derived from out_valid): EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY → FULL on an accepted last beat.
  - FULL → EMPTY on out_ready with no accepted last beat.
  - FULL → FULL on out_ready plus an accepted last beat.
- Accumulation continues in FULL while out_ready=1; it stalls only when in_ready=0.
- No combinational path from in_valid to out_valid. out_ready → in_ready is combinational by design.

Decomposition:
- Package bnn_acc_pkg holds:
  - localparam POP_W=7, WORD_BITS=64.
  - function term_of(pop, plane) returning the signed shifted term.
  - function sat_add(a, b) returning {ovf, sum} at ACC_W.
- One sub-module is natural: popcount_term, combinational pop/plane → signed term. It is reused by a future multi-lane adder tree.
- FSM, accumulator and output register stay in the top module.

Test Plan:
- Reset then single beat pop=64, plane=0, last=1, out_ready=1 → next cycle out_valid=1, out_sum=+64, out_ovf=0.
- Packet of 3 beats (pop=32/p0, pop=40/p1, pop=0/p2 last) → out_sum = 0 + 32 + (−256) = −224.
- Hold out_ready=0 after a result, drive in_valid=1:
  - Expect in_ready=0 and out_sum stable for 5 cycles.
  - Raise out_ready: result consumed, next beat accepted the same cycle.
- Back-to-back single-beat packets pop=33, 31, 64 with out_ready=1 continuously → out_sum sequence +2, −2, +64 on consecutive cycles, out_valid never drops.
- ACC_W=10 build, 3 beats pop=64 plane=3 (+512 each) → out_sum=+511, out_ovf=1; following packet pop=32, last=1 → out_sum=0, out_ovf=0.
- Assert rst for one cycle mid-packet after 2 beats (+64, +64), then send pop=40, last=1 → out_sum=+16 (earlier beats discarded); rst while out_valid=1 → out_valid=0 next cycle.
